// File: rtl/galois_lfsr_gen.sv
// Galois LFSR pseudo-random word generator with valid/ready output, output enable,
// zero-seed lockup protection and an accepted-word counter.
module galois_lfsr_gen #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h4002100B),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h00000001),
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             pre,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             run,
    input  logic             oe,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] o,
    output logic             lockup,
    output logic [31:0]      word_count
);

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("galois_lfsr_gen: WIDTH must be in 4..64");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("galois_lfsr_gen: STEPS must be in 1..WIDTH");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("galois_lfsr_gen: SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } state_t;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_d;
    logic             r_v;
    logic             r_lockup;
    logic [31:0]      r_count;
    state_t           r_fsm;

    state_t           w_fsm_nxt;
    logic             w_advance;
    logic             w_v_nxt;
    logic             w_accept;
    logic             w_free;
    logic [WIDTH-1:0] w_adv;
    logic [WIDTH-1:0] w_stage [STEPS+1];

    // Unrolled chain of STEPS single Galois steps, evaluated in one cycle.
    assign w_stage[0] = r_state;
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        assign w_stage[k+1] = {w_stage[k][WIDTH-2:0], 1'b0}
                            ^ (w_stage[k][WIDTH-1] ? POLY : '0);
    end
    assign w_adv = w_stage[STEPS];

    assign w_accept = oe & r_v & out_ready;
    assign w_free   = ~r_v | w_accept;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_fsm_nxt = r_fsm;
        w_advance = 1'b0;
        w_v_nxt   = r_v & ~w_accept;
        case (r_fsm)
            ST_IDLE: begin
                if (run && w_free) begin
                    w_advance = 1'b1;
                    w_fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run && w_free) begin
                    w_advance = 1'b1;
                end else if (run) begin
                    w_fsm_nxt = ST_STALL;
                end else begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (w_accept && run) begin
                    w_advance = 1'b1;
                    w_fsm_nxt = ST_RUN;
                end else if (w_accept) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
        if (w_advance) begin
            w_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state  <= SEED;
            r_d      <= '0;
            r_v      <= 1'b0;
            r_lockup <= 1'b0;
            r_count  <= '0;
            r_fsm    <= ST_IDLE;
        end else if (pre) begin
            r_state <= '1;
            r_d     <= '0;
            r_v     <= 1'b0;
            r_fsm   <= ST_IDLE;
        end else if (load) begin
            // A zero seed would lock the LFSR at zero forever; substitute SEED and flag it.
            if (seed == '0) begin
                r_state  <= SEED;
                r_lockup <= 1'b1;
            end else begin
                r_state <= seed;
            end
            r_d   <= '0;
            r_v   <= 1'b0;
            r_fsm <= ST_IDLE;
        end else begin
            if (w_advance) begin
                r_state <= w_adv;
                r_d     <= w_adv;
            end
            r_v   <= w_v_nxt;
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign out_valid  = r_v & oe;
    assign o          = oe ? r_d : '0;
    assign lockup     = r_lockup;
    assign word_count = r_count;

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Directed bench for galois_lfsr_gen: default polynomial with STEPS=1 plus an
// 8-step instance driven by the same stimulus.
module tb_galois_lfsr_gen;

    logic        clk = 1'b0;
    logic        clear, pre, load, run, oe, out_ready;
    logic [31:0] seed;
    logic        out_valid, lockup;
    logic [31:0] o, word_count;
    logic        out_valid8, lockup8;
    logic [31:0] o8, word_count8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    galois_lfsr_gen u_dut (
        .clk(clk), .clear(clear), .pre(pre), .load(load), .seed(seed),
        .run(run), .oe(oe), .out_ready(out_ready),
        .out_valid(out_valid), .o(o), .lockup(lockup), .word_count(word_count)
    );

    galois_lfsr_gen #(.STEPS(8)) u_dut8 (
        .clk(clk), .clear(clear), .pre(pre), .load(load), .seed(seed),
        .run(run), .oe(oe), .out_ready(out_ready),
        .out_valid(out_valid8), .o(o8), .lockup(lockup8), .word_count(word_count8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1; pre = 1'b0; load = 1'b0; seed = '0;
        run = 1'b0; oe = 1'b1; out_ready = 1'b1;
        tick(); tick();
        clear = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_o", o, 0);
        check("rst_lockup", lockup, 0);
        check("rst_count", word_count, 0);

        // Basic stream, one word per cycle
        run = 1'b1;
        tick();
        check("w1_valid", out_valid, 1);
        check("w1", o, 32'h00000002);
        check("s8_w1", o8, 32'h00000100);
        tick();
        check("w2", o, 32'h00000004);
        check("s8_w2", o8, 32'h00010000);
        check("w2_count", word_count, 1);
        tick();
        check("w3", o, 32'h00000008);
        run = 1'b0;
        tick();
        check("w3_count", word_count, 3);
        check("drain_valid", out_valid, 0);

        // Feedback tap from MSB
        load = 1'b1; seed = 32'h80000000;
        tick();
        load = 1'b0;
        check("load_flush", out_valid, 0);
        run = 1'b1;
        tick();
        check("fb_word", o, 32'h4002100B);
        run = 1'b0;
        tick();
        check("fb_count", word_count, 4);

        // Backpressure
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", word_count, 0);
        run = 1'b1; out_ready = 1'b0;
        tick();
        check("bp_first", o, 32'h00000002);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_o", o, 32'h00000002);
            check("bp_hold_cnt", word_count, 0);
            check("bp_hold_v", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next", o, 32'h00000004);
        check("bp_cnt1", word_count, 1);
        tick();
        check("bp_next2", o, 32'h00000008);

        // Output enable gating re-presents the held word
        oe = 1'b0;
        tick();
        check("oe_valid", out_valid, 0);
        check("oe_o", o, 0);
        check("oe_cnt", word_count, 2);
        oe = 1'b1;
        #1;
        check("oe_repres", o, 32'h00000008);
        tick();
        check("oe_after", o, 32'h00000010);
        check("oe_after_cnt", word_count, 3);

        // Zero-seed lockup protection
        run = 1'b0;
        load = 1'b1; seed = 32'h0;
        tick();
        load = 1'b0;
        check("lock_set", lockup, 1);
        check("lock_flush", out_valid, 0);
        run = 1'b1;
        tick();
        check("lock_word", o, 32'h00000002);
        check("lock_sticky", lockup, 1);
        tick();
        check("lock_word2", o, 32'h00000004);

        // Clear mid-stream
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mclr_valid", out_valid, 0);
        check("mclr_o", o, 0);
        check("mclr_cnt", word_count, 0);
        check("mclr_lock", lockup, 0);
        tick();
        check("mclr_restart", o, 32'h00000002);

        // Preset to all ones
        pre = 1'b1;
        tick();
        pre = 1'b0;
        check("pre_valid", out_valid, 0);
        tick();
        check("pre_word", o, 32'hBFFDEFF5);
        check("pre_cnt", word_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
